cnn_frame_sequencer: RTL

//  Frame-level controller for the conv3x3 -> ReLU -> 3x3 max-pool pipeline. On start it latches
//  and checks the frame config, streams W*H pixels from a pixel SRAM into the pipeline and drives
//  the pipeline's static config. It then counts pooled results, tags each with its raster index
//  and reports done or error.

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/cnn_cfg_check.sv | 21 ++
 rtl/cnn_frame_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and output-count helper for the CNN frame sequencer.
package cnn_pkg;

    localparam logic [1:0] PAD_NONE    = 2'b00;
    localparam logic [1:0] PAD_ZERO    = 2'b01;
    localparam logic [1:0] PAD_EDGE    = 2'b10;
    localparam logic [1:0] PAD_ILLEGAL = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_CFG      = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN
    } seq_state_t;

    // Without padding the conv stage trims a 1-pixel border; the 3x3 pool always trims one more.
    function automatic logic [15:0] expected_outputs(input logic [7:0] w,
                                                     input logic [7:0] h,
                                                     input logic [1:0] pad);
        logic [15:0] fw;
        logic [15:0] fh;
        fw = (pad == PAD_NONE) ? ({8'd0, w} - 16'd2) : {8'd0, w};
        fh = (pad == PAD_NONE) ? ({8'd0, h} - 16'd2) : {8'd0, h};
        return (fw - 16'd2) * (fh - 16'd2);
    endfunction

endpackage

// File: rtl/cnn_cfg_check.sv
// Combinational frame-config legality check plus pixel and result count derivation.
module cnn_cfg_check
    import cnn_pkg::*;
(
    input  logic [7:0]  width,
    input  logic [7:0]  height,
    input  logic [1:0]  padding,
    output logic        cfg_ok,
    output logic [15:0] expected,
    output logic [15:0] total
);

    logic [7:0] min_dim;

    // Unpadded frames lose two pixels per axis before pooling, so they need a larger minimum.
    assign min_dim  = (padding == PAD_NONE) ? 8'd5 : 8'd3;
    assign cfg_ok   = (padding != PAD_ILLEGAL) && (width >= min_dim) && (height >= min_dim);
    assign expected = expected_outputs(width, height, padding);
    assign total    = {8'd0, width} * {8'd0, height};

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller: streams a frame from pixel SRAM into the conv/ReLU/pool pipeline
// and counts, tags and forwards the pooled results.
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        cfg_width,
    input  logic [7:0]        cfg_height,
    input  logic [1:0]        cfg_padding,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              pix_valid,
    output logic [7:0]        pix_data,
    output logic [7:0]        img_width,
    output logic [7:0]        img_height,
    output logic [1:0]        padding_mode,
    input  logic              res_valid,
    input  logic [7:0]        res_data,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [15:0]       out_index,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error
);

    localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [ADDR_W-1:0] rd_cnt;
    logic [15:0]       res_cnt;
    logic [15:0]       res_cnt_next;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_next;
    logic              cfg_ok;
    logic [15:0]       expected;
    logic [15:0]       total;
    logic              rd_en;
    logic              load_cfg;
    logic              done_set;
    logic              res_accept;
    logic [1:0]        err_next;

    cnn_cfg_check u_cfg_check (
        .width    (img_width),
        .height   (img_height),
        .padding  (padding_mode),
        .cfg_ok   (cfg_ok),
        .expected (expected),
        .total    (total)
    );

    assign res_accept   = res_valid && (state != ST_IDLE);
    assign res_cnt_next = res_cnt + 16'(res_accept);
    assign idle_next    = res_valid ? '0 : idle_cnt + 1'b1;
    assign mem_rd_en    = rd_en;
    assign mem_addr     = rd_cnt;
    assign busy         = (state != ST_IDLE);
    // SRAM data lands the cycle after the strobe, which is exactly when pix_valid is high.
    assign pix_data     = pix_valid ? mem_rdata : '0;

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        load_cfg   = 1'b0;
        done_set   = 1'b0;
        err_next   = error;
        if (res_accept && (res_cnt >= expected)) begin
            err_next = ERR_OVERFLOW;
        end
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load_cfg   = 1'b1;
                    err_next   = ERR_OK;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!cfg_ok) begin
                    err_next   = ERR_CFG;
                    done_set   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    if (rd_cnt == ADDR_W'(total - 16'd1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Completion is checked first so a final result on the timeout cycle still succeeds.
                if (res_cnt_next >= expected) begin
                    done_set   = 1'b1;
                    state_next = ST_IDLE;
                end else if (idle_next == IDLE_W'(DRAIN_TIMEOUT)) begin
                    err_next   = ERR_TIMEOUT;
                    done_set   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt       <= '0;
            res_cnt      <= '0;
            idle_cnt     <= '0;
            pix_valid    <= 1'b0;
            img_width    <= '0;
            img_height   <= '0;
            padding_mode <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_index    <= '0;
            done         <= 1'b0;
            error        <= ERR_OK;
        end else begin
            pix_valid <= rd_en;
            done      <= done_set;
            error     <= err_next;
            out_valid <= res_accept;
            if (res_accept) begin
                out_data  <= res_data;
                out_index <= res_cnt;
            end
            if (load_cfg) begin
                img_width    <= cfg_width;
                img_height   <= cfg_height;
                padding_mode <= cfg_padding;
                rd_cnt       <= '0;
                res_cnt      <= '0;
            end else begin
                if (rd_en) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                res_cnt <= res_cnt_next;
            end
            idle_cnt <= (state == ST_DRAIN) ? idle_next : '0;
        end
    end

endmodule
